// File: rtl/triple_pkg.sv
// triple_unit shared constants and arithmetic helpers.
// times3 is the single source of the shift-add product for both paths.
package triple_pkg;

    localparam int WIDTH_DEF = 4;

    function automatic int res_w(input int width);
        return width + 2;
    endfunction

    function automatic logic [31:0] times3(input logic [31:0] value);
        return (value << 1) + value;
    endfunction

endpackage

// File: rtl/triple_if.sv
// valid/ready stream bundle used between triple_unit and its skid buffer.
// master drives valid/data, slave drives ready.
interface triple_if #(
    parameter int W = 6
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/triple_skid_buf.sv
// Two-entry valid/ready skid buffer: main register plus skid register.
// ready is registered and tracks "skid register empty".
module triple_skid_buf #(
    parameter int DW = 6
) (
    input logic     clk,
    input logic     rst_n,
    triple_if.slave  up,
    triple_if.master dn
);

    logic          m_v;
    logic [DW-1:0] m_d;
    logic          s_v;
    logic [DW-1:0] s_d;
    logic          rdy;
    logic          acc;
    logic          drn;

    assign acc = up.valid & rdy;
    assign drn = m_v & dn.ready;

    assign up.ready = rdy;
    assign dn.valid = m_v;
    assign dn.data  = m_d;

    // skid only fills while main is held, so ready=0 implies main is full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v <= 1'b0;
            m_d <= '0;
            s_v <= 1'b0;
            s_d <= '0;
            rdy <= 1'b1;
        end else if (drn) begin
            if (s_v) begin
                m_d <= s_d;
                s_v <= 1'b0;
                rdy <= 1'b1;
            end else if (acc) begin
                m_d <= up.data;
            end else begin
                m_v <= 1'b0;
            end
        end else if (acc) begin
            if (!m_v) begin
                m_v <= 1'b1;
                m_d <= up.data;
            end else begin
                s_v <= 1'b1;
                s_d <= up.data;
                rdy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/triple_unit.sv
// Multiply-by-3 helper: instant combinational product plus a
// registered, back-pressurable product behind a 2-entry skid buffer.
module triple_unit
    import triple_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    localparam int RES_W = res_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    output logic [RES_W-1:0] result,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_result
);

    triple_if #(.W(RES_W)) up_if ();
    triple_if #(.W(RES_W)) dn_if ();

    assign result = RES_W'(times3(32'(a)));

    assign up_if.valid = in_valid;
    assign up_if.data  = RES_W'(times3(32'(in_data)));
    assign in_ready    = up_if.ready;

    assign out_valid   = dn_if.valid;
    assign out_result  = dn_if.data;
    assign dn_if.ready = out_ready;

    triple_skid_buf #(.DW(RES_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (up_if.slave),
        .dn    (dn_if.master)
    );

endmodule

// File: tb/tb_triple_unit.sv
// Directed bench for triple_unit: comb sweep, streaming, backpressure,
// async reset, bubbles, and a WIDTH=8 instance.
module tb_triple_unit;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic [3:0] a;
    logic [5:0] result;

    triple_if #(.W(4)) src ();
    triple_if #(.W(6)) snk ();

    logic [7:0] a8;
    logic [9:0] res8;
    logic       iv8;
    logic       ir8;
    logic [7:0] id8;
    logic       ov8;
    logic       ordy8;
    logic [9:0] or8;

    int total;
    int bad;

    triple_unit #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .result     (result),
        .in_valid   (src.valid),
        .in_ready   (src.ready),
        .in_data    (src.data),
        .out_valid  (snk.valid),
        .out_ready  (snk.ready),
        .out_result (snk.data)
    );

    triple_unit #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a8),
        .result     (res8),
        .in_valid   (iv8),
        .in_ready   (ir8),
        .in_data    (id8),
        .out_valid  (ov8),
        .out_ready  (ordy8),
        .out_result (or8)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [5:0] d, input logic r);
        chk({tag, ".v"}, 32'(snk.valid), 32'(v));
        if (v) chk({tag, ".d"}, 32'(snk.data), 32'(d));
        chk({tag, ".rdy"}, 32'(src.ready), 32'(r));
    endtask

    logic [3:0] av [6] = '{4'd0, 4'd1, 4'd3, 4'd5, 4'd10, 4'd15};
    logic [5:0] rv [6] = '{6'd0, 6'd3, 6'd9, 6'd15, 6'd30, 6'd45};

    initial begin
        total     = 0;
        bad       = 0;
        clk_en    = 1'b0;
        rst_n     = 1'b1;
        a         = '0;
        src.valid = 1'b0;
        src.data  = '0;
        snk.ready = 1'b0;
        a8        = '0;
        iv8       = 1'b0;
        id8       = '0;
        ordy8     = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst.v", 32'(snk.valid), 32'd0);
        chk("rst.d", 32'(snk.data), 32'd0);
        chk("rst.rdy", 32'(src.ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            a = av[i];
            #1;
            chk("comb.tab", 32'(result), 32'(rv[i]));
        end
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            #1;
            chk("comb.all", 32'(result), 32'(i * 3));
        end
        a8 = 8'd255;
        #1;
        chk("comb.w8", 32'(res8), 32'd765);

        clk_en = 1'b1;
        step();
        step();
        rst_n = 1'b1;

        // streaming, out_ready held high
        snk.ready = 1'b1;
        src.valid = 1'b1;
        src.data  = 4'd2;
        step();
        chk_out("str0", 1'b1, 6'd6, 1'b1);
        src.data = 4'd7;
        step();
        chk_out("str1", 1'b1, 6'd21, 1'b1);
        src.data = 4'd15;
        step();
        chk_out("str2", 1'b1, 6'd45, 1'b1);
        src.valid = 1'b0;
        step();
        chk_out("str3", 1'b0, 6'd0, 1'b1);

        // backpressure
        snk.ready = 1'b0;
        src.valid = 1'b1;
        src.data  = 4'd4;
        step();
        chk_out("bp0", 1'b1, 6'd12, 1'b1);
        src.data = 4'd9;
        step();
        chk_out("bp1", 1'b1, 6'd12, 1'b0);
        src.valid = 1'b0;
        step();
        chk_out("bp2", 1'b1, 6'd12, 1'b0);
        snk.ready = 1'b1;
        step();
        chk_out("bp3", 1'b1, 6'd27, 1'b1);
        step();
        chk_out("bp4", 1'b0, 6'd0, 1'b1);

        // async reset with both registers full
        snk.ready = 1'b0;
        src.valid = 1'b1;
        src.data  = 4'd4;
        step();
        src.data = 4'd9;
        step();
        src.valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.v", 32'(snk.valid), 32'd0);
        chk("arst.d", 32'(snk.data), 32'd0);
        chk("arst.rdy", 32'(src.ready), 32'd1);
        step();
        rst_n     = 1'b1;
        snk.ready = 1'b1;
        src.valid = 1'b1;
        src.data  = 4'd1;
        step();
        chk_out("post0", 1'b1, 6'd3, 1'b1);
        src.valid = 1'b0;
        step();
        chk_out("post1", 1'b0, 6'd0, 1'b1);

        // bubbles with X on idle beats
        for (int i = 0; i < 4; i++) begin
            src.valid = 1'b1;
            src.data  = 4'd5;
            step();
            chk_out("bub.on", 1'b1, 6'd15, 1'b1);
            src.valid = 1'b0;
            src.data  = 'x;
            step();
            chk_out("bub.off", 1'b0, 6'd0, 1'b1);
        end

        // registered path at WIDTH=8
        ordy8 = 1'b1;
        iv8   = 1'b1;
        id8   = 8'd255;
        step();
        chk("w8.v", 32'(ov8), 32'd1);
        chk("w8.d", 32'(or8), 32'd765);
        chk("w8.rdy", 32'(ir8), 32'd1);
        iv8 = 1'b0;
        step();
        chk("w8.idle", 32'(ov8), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/triple_unit.md
Name: triple_unit

Overview:
- Multiplies an unsigned operand by 3 using shift-add (a<<1 + a); no multiplier inference.
- Two outputs:
  - Combinational result port, valid in the same delta as the input.
  - Registered, flow-controlled result path with a valid/ready handshake and a 2-entry skid buffer.
- Used as a small arithmetic helper in datapaths that need either an instant product or a pipelined, back-pressurable one.

Parameters:
- WIDTH, 4, operand width in bits (minimum 1).
- RES_W, WIDTH+2, result width. Derived, not overridable; 3*(2^WIDTH-1) always fits, so there is never overflow.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  unsigned operand for the combinational path.
- result  output  RES_W  combinational 3*a.
- in_valid  input  1  in_data is presented for the registered path.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  WIDTH  unsigned operand for the registered path.
- out_valid  output  1  out_result holds a valid product.
- out_ready  input  1  downstream accepts out_result this cycle.
- out_result  output  RES_W  registered 3*in_data.

Behaviour:
- Combinational path:
  - result = zero-extend(a)<<1 + zero-extend(a), computed at RES_W bits.
  - No dependence on clk or rst_n.
  - Output settles within the same timestep as a changes; no latency.
- Registered path handshake:
  - Input transfer occurs when in_valid & in_ready at a rising clk.
  - Output transfer occurs when out_valid & out_ready at a rising clk.
  - Latency: a product accepted at edge N is visible on out_result with out_valid=1 after edge N (first available edge N+1 for transfer).
  - Throughput: 1 transfer/cycle when out_ready is held high.
- Storage: a main register plus a skid register; each holds a product and a valid bit.
- Both registers empty: the accepted product goes to main.
- Main full and downstream stalled (out_ready=0) while an input is accepted: the product goes to skid.
- in_ready is registered and equals "skid register empty". It deasserts only when skid holds data.
- When main drains (out_ready=1) and skid is full: skid moves to main, skid empties, and in_ready rises the following cycle.
- Simultaneous input accept and output drain with skid empty: main is replaced by the new product; out_valid stays 1.
- Ordering is strictly FIFO; no product is dropped or duplicated.
- out_result and out_valid are stable while out_valid=1 and out_ready=0.
- in_valid may drop without a transfer; there is no requirement that it stay asserted.
- Asynchronous reset (rst_n low, any time, including mid-transfer):
  - out_valid=0, out_result=0, in_ready=1.
  - Skid register cleared; all stored products discarded.
- Release from reset is synchronous to clk. First acceptance is possible at the first rising edge after rst_n goes high.
- X on in_data when in_valid=0 must not propagate to out_result.

Decomposition:
- Package triple_pkg holds:
  - Default WIDTH constant.
  - Function res_w(width) returning width+2.
  - Function times3(value) implementing shift-add; used by both paths so the arithmetic is identical.
- Sub-module triple_skid_buf: generic 2-entry valid/ready skid buffer, parameterised on data width (RES_W).
  - triple_unit instantiates it and feeds it times3(in_data).

Test Plan:
- Combinational sweep with 1 time unit between steps, no clock activity:
  - a = 0, 1, 3, 5, 10, 15 -> result = 0, 3, 9, 15, 30, 45.
  - Exhaustive 0..15 matches 3*a with no truncation.
- Streaming with out_ready=1 and in_valid=1:
  - in_data 2, 7, 15 on consecutive edges -> out_result 6, 21, 45 on the following consecutive cycles.
  - in_ready remains 1 throughout.
- Backpressure:
  - Hold out_ready=0 and send 4 then 9 -> in_ready falls after the second accept; out_result holds 12.
  - Raise out_ready -> 12 then 27 delivered in order; in_ready returns to 1.
- Reset mid-operation:
  - Fill both registers, then pulse rst_n low between clock edges -> out_valid=0, out_result=0, in_ready=1 immediately, with no clock edge.
  - After release, send 1 -> out_result 3 only.
- Idle/bubble:
  - Alternate in_valid 1/0 with in_data 5 and X -> out_result is 15 only on valid beats.
  - X never appears while out_valid=1.
- Parameter check at WIDTH=8:
  - a = 255 -> result = 765 (10 bits).
  - Registered path also yields 765.
